ir_fetch: RTL and testbench
===========================

Name: ir_fetch

Overview:
- Instruction-fetch front end that feeds the control unit.
- Fetches one 8-bit opcode per request from program memory over a req/ack handshake.
- Holds the opcode in the instruction register, drives it to the CU's data_from_ir input, and maintains the program counter.
- Sits between program memory and cu. The CU drives fetch_en and pc_load from its control_signal bits.

Parameters:
ADDR_W, 8, program counter / memory address width
DATA_W, 8, instruction width (matches data_from_ir)
RESET_PC, 0, PC value after reset
TIMEOUT_CYCLES, 15, ack wait limit; used only when FETCH_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
fetch_en  input  1  CU request to fetch the next instruction
pc_load  input  1  CU request to load the PC (jump/branch taken)
pc_load_val  input  ADDR_W  new PC value for pc_load
mem_addr  output  ADDR_W  program memory address; always equals pc
mem_rd  output  1  memory read request, registered
mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1
mem_ack  input  1  memory acknowledge, sampled only while mem_rd=1
data_from_ir  output  DATA_W  instruction register contents, to CU
ir_valid  output  1  data_from_ir holds a freshly fetched instruction
pc  output  ADDR_W  current program counter
busy  output  1  fetch in flight (state REQ)
fetch_err  output  1  ack timeout flag; tied 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, mem_rd=0, busy=0, fetch_err=0. Reset mid-fetch aborts immediately; a later mem_ack is ignored.
- States: IDLE, REQ. mem_rd=busy=(state==REQ). mem_addr=pc combinationally.
- IDLE:
  - pc_load=1: pc<=pc_load_val, ir_valid<=0, stay in IDLE. A simultaneous fetch_en is ignored.
  - Else fetch_en=1: go to REQ, ir_valid<=0.
  - Else: hold all state.
- REQ:
  - pc_load=1 has priority. Cancel the fetch: pc<=pc_load_val, go to IDLE, ir unchanged, ir_valid stays 0. A mem_ack in the same cycle is discarded.
  - Else mem_ack=1: ir<=mem_rdata, ir_valid<=1, pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0), go to IDLE.
  - Else: stay in REQ with mem_rd held high and mem_addr stable.
  - fetch_en in REQ is ignored.
- Latency: fetch_en sampled at edge k; mem_rd high after edge k. With mem_ack high in that cycle, ir and ir_valid update at edge k+1. Minimum is 2 edges from request to valid.
- ir_valid stays high until the next accepted fetch_en or pc_load. data_from_ir holds its value indefinitely otherwise.
- mem_ack while in IDLE is ignored.
- Back-to-back: fetch_en held high re-enters REQ on the edge after returning to IDLE. Throughput is 1 instruction per 2 cycles at zero wait states.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined, a wait counter clears on entry to REQ and increments each REQ cycle without mem_ack. When it reaches TIMEOUT_CYCLES:
  - ir<=0 (NOP), ir_valid<=1, fetch_err<=1, go to IDLE.
  - pc is not incremented.
- fetch_err is sticky until reset or the next accepted fetch_en.
- When not defined: no counter, REQ waits indefinitely, fetch_err is constant 0.

Test Plan:
- Reset then single fetch: rst low 60 ns then high, mem returns 8'h02 with 0 wait states, fetch_en pulsed -> mem_rd high for 1 cycle at mem_addr=0x00, data_from_ir=8'h02, ir_valid=1, pc=0x01 two edges after fetch_en.
- Wait states: mem_ack delayed 3 cycles -> mem_rd and mem_addr stable for 4 cycles, busy=1 throughout, ir loads only on the ack edge.
- Jump cancel: pc_load=1 with pc_load_val=0x40 in the same cycle as mem_ack (rdata 8'hAA) -> ir unchanged, ir_valid=0, pc=0x40, state IDLE. The next fetch reads address 0x40.
- PC wrap: pc_load_val=0xFF, then fetch -> pc=0x00 after ack.
- Async reset mid-fetch: rst=0 while in REQ between clock edges -> mem_rd=0 immediately, pc=RESET_PC. A late mem_ack after release has no effect.
- FETCH_TIMEOUT_EN defined, mem_ack never asserted -> after 15 REQ cycles: fetch_err=1, data_from_ir=8'h00, ir_valid=1, pc unchanged. The next fetch_en clears fetch_err.

Source files
------------

// File: rtl/ir_fetch.sv
// Instruction fetch front end: fetches one opcode per request over req/ack and holds it in the IR for the CU.
// Latency: 2 edges from fetch_en to ir_valid with zero memory wait states; 1 instruction per 2 cycles back-to-back.
// Backpressure: mem_rd and mem_addr stay held until mem_ack; fetch_en is ignored while a fetch is in flight.
//
// Ports: clk/rst (async, active-low); fetch_en, pc_load, pc_load_val from the CU;
//        mem_addr/mem_rd/mem_rdata/mem_ack program-memory handshake;
//        data_from_ir/ir_valid/pc/busy/fetch_err status back to the CU.
// Optional feature macro: FETCH_TIMEOUT_EN (ack timeout -> NOP + sticky fetch_err).
module ir_fetch #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] data_from_ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_q, pc_nx;
    logic [DATA_W-1:0] ir_q, ir_nx;
    logic              ir_vld_q, ir_vld_nx;

    // A zero or negative limit would make the timeout fire on entry; keep it a positive count.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_invalid
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             err_q, err_nx;
`endif

    always_comb begin
        state_nx  = state;
        pc_nx     = pc_q;
        ir_nx     = ir_q;
        ir_vld_nx = ir_vld_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_nx = wait_cnt;
        err_nx      = err_q;
`endif
        case (state)
            IDLE: begin
                // A jump wins over a simultaneous fetch request.
                if (pc_load) begin
                    pc_nx     = pc_load_val;
                    ir_vld_nx = 1'b0;
                end else if (fetch_en) begin
                    state_nx  = REQ;
                    ir_vld_nx = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_nx = '0;
                    err_nx      = 1'b0;
`endif
                end
            end
            REQ: begin
                // A jump cancels the outstanding fetch; any ack in that cycle is dropped.
                if (pc_load) begin
                    pc_nx    = pc_load_val;
                    state_nx = IDLE;
                end else if (mem_ack) begin
                    ir_nx     = mem_rdata;
                    ir_vld_nx = 1'b1;
                    pc_nx     = pc_q + ADDR_W'(1);
                    state_nx  = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                // The count reaches TIMEOUT_CYCLES on the last waiting cycle: deliver a NOP
                // and flag the error without advancing the PC.
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    ir_nx     = '0;
                    ir_vld_nx = 1'b1;
                    err_nx    = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc_q     <= ADDR_W'(RESET_PC);
            ir_q     <= '0;
            ir_vld_q <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_q     <= pc_nx;
            ir_q     <= ir_nx;
            ir_vld_q <= ir_vld_nx;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nx;
            err_q    <= err_nx;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_rd       = (state == REQ);
    assign busy         = (state == REQ);
    assign mem_addr     = pc_q;
    assign pc           = pc_q;
    assign data_from_ir = ir_q;
    assign ir_valid     = ir_vld_q;

endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: a vector table for the single-cycle behaviour, then
// hand-written sequences for wait states, async reset mid-fetch and the ack timeout.
module tb_ir_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fetch_en = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = 8'h00;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic [7:0] data_from_ir;
    logic       ir_valid;
    logic [7:0] pc;
    logic       busy;
    logic       fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ir_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .pc_load      (pc_load),
        .pc_load_val  (pc_load_val),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .data_from_ir (data_from_ir),
        .ir_valid     (ir_valid),
        .pc           (pc),
        .busy         (busy),
        .fetch_err    (fetch_err)
    );

    typedef struct {
        logic       fe;
        logic       pl;
        logic [7:0] plv;
        logic       ack;
        logic [7:0] rdata;
        logic       e_rd;
        logic [7:0] e_pc;
        logic [7:0] e_ir;
        logic       e_iv;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fe, input logic pl, input logic [7:0] plv,
                         input logic ack, input logic [7:0] rdata);
        @(negedge clk);
        fetch_en    = fe;
        pc_load     = pl;
        pc_load_val = plv;
        mem_ack     = ack;
        mem_rdata   = rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs applied before an edge; expected outputs sampled just after it.
        //            fe  pl  plv    ack rdata   rd  pc     ir     iv
        vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h00,8'h00,1'b0}; // request at 0x00
        vecs[1]  = '{1'b0,1'b0,8'h00,1'b1,8'h02, 1'b0,8'h01,8'h02,1'b1}; // zero-wait ack
        vecs[2]  = '{1'b0,1'b0,8'h00,1'b1,8'h55, 1'b0,8'h01,8'h02,1'b1}; // ack in IDLE ignored
        vecs[3]  = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h01,8'h02,1'b0}; // new fetch drops valid
        vecs[4]  = '{1'b0,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h01,8'h02,1'b0}; // wait state
        vecs[5]  = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h01,8'h02,1'b0}; // fetch_en in REQ ignored
        vecs[6]  = '{1'b0,1'b0,8'h00,1'b1,8'hA5, 1'b0,8'h02,8'hA5,1'b1}; // ack
        vecs[7]  = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h02,8'hA5,1'b0}; // request at 0x02
        vecs[8]  = '{1'b0,1'b1,8'h40,1'b1,8'hAA, 1'b0,8'h40,8'hA5,1'b0}; // jump cancels, ack dropped
        vecs[9]  = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h40,8'hA5,1'b0}; // fetch from jump target
        vecs[10] = '{1'b1,1'b0,8'h00,1'b1,8'h3C, 1'b0,8'h41,8'h3C,1'b1}; // ack, fetch_en held
        vecs[11] = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h41,8'h3C,1'b0}; // back-to-back re-entry
        vecs[12] = '{1'b0,1'b0,8'h00,1'b1,8'h77, 1'b0,8'h42,8'h77,1'b1}; // ack
        vecs[13] = '{1'b1,1'b1,8'hFF,1'b0,8'h00, 1'b0,8'hFF,8'h77,1'b0}; // load wins over fetch
        vecs[14] = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,8'hFF,8'h77,1'b0}; // request at 0xFF
        vecs[15] = '{1'b0,1'b0,8'h00,1'b1,8'h09, 1'b0,8'h00,8'h09,1'b1}; // pc wraps to 0x00

        // Reset state, sampled while reset is held.
        #30;
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pc", pc, 8'h00);
        check("rst_ir", data_from_ir, 8'h00);
        check("rst_ir_valid", ir_valid, 1'b0);
        check("rst_fetch_err", fetch_err, 1'b0);
        #30;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].fe, vecs[i].pl, vecs[i].plv, vecs[i].ack, vecs[i].rdata);
            check($sformatf("v%0d_mem_rd", i), mem_rd, vecs[i].e_rd);
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_rd);
            check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_pc);
            check($sformatf("v%0d_ir", i), data_from_ir, vecs[i].e_ir);
            check($sformatf("v%0d_ir_valid", i), ir_valid, vecs[i].e_iv);
        end

        // Three wait states: request held stable for 4 cycles, IR loads only on the ack edge.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("ws_req_rd", mem_rd, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 8'hEE);
            check($sformatf("ws%0d_rd", i), mem_rd, 1'b1);
            check($sformatf("ws%0d_busy", i), busy, 1'b1);
            check($sformatf("ws%0d_addr", i), mem_addr, 8'h00);
            check($sformatf("ws%0d_ir", i), data_from_ir, 8'h09);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hC3);
        check("ws_ack_ir", data_from_ir, 8'hC3);
        check("ws_ack_valid", ir_valid, 1'b1);
        check("ws_ack_pc", pc, 8'h01);
        check("ws_ack_rd", mem_rd, 1'b0);

        // Async reset between edges while in REQ.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        fetch_en = 1'b0;
        check("ar_pre_busy", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_mem_rd", mem_rd, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_pc", pc, 8'h00);
        check("ar_ir", data_from_ir, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hEE);
            check($sformatf("ar_late%0d_rd", i), mem_rd, 1'b0);
            check($sformatf("ar_late%0d_ir", i), data_from_ir, 8'h00);
            check($sformatf("ar_late%0d_valid", i), ir_valid, 1'b0);
            check($sformatf("ar_late%0d_pc", i), pc, 8'h00);
        end

        // Unacknowledged fetch.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("to_enter_busy", busy, 1'b1);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        end
        check("to_wait_busy", busy, 1'b1);
        check("to_wait_err", fetch_err, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("to_busy", busy, 1'b0);
        check("to_err", fetch_err, 1'b1);
        check("to_ir", data_from_ir, 8'h00);
        check("to_valid", ir_valid, 1'b1);
        check("to_pc", pc, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("to_err_sticky", fetch_err, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("to_err_clear", fetch_err, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
        check("to_recover_ir", data_from_ir, 8'h11);
        check("to_recover_pc", pc, 8'h01);
`else
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        end
        check("nto_busy", busy, 1'b1);
        check("nto_err", fetch_err, 1'b0);
        check("nto_addr", mem_addr, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
        check("nto_ack_ir", data_from_ir, 8'h11);
        check("nto_ack_pc", pc, 8'h01);
        check("nto_ack_valid", ir_valid, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
